// File: rtl/snake_pkg.sv
// Shared types and constants for the snake self-collision / food checker.
package snake_pkg;

    localparam int unsigned SEG_W   = 8;
    localparam int unsigned GRID_W  = 4;
    localparam int unsigned MAX_SEG = 225;
    localparam int unsigned LEN_W   = 8;

    localparam logic [GRID_W-1:0] FOOD_RST_X = 4'd3;
    localparam logic [GRID_W-1:0] FOOD_RST_Y = 4'd3;
    localparam logic [GRID_W-1:0] FOOD_DX    = 4'd5;
    localparam logic [GRID_W-1:0] FOOD_DY    = 4'd3;
    localparam logic [7:0]        LFSR_SEED  = 8'h5A;

    typedef struct packed {
        logic [GRID_W-1:0] y;
        logic [GRID_W-1:0] x;
    } seg_t;

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        DONE
    } state_t;

    // Fibonacci step for x^8+x^6+x^5+x^4+1, shifting toward the MSB.
    function automatic logic [7:0] lfsr8_next(input logic [7:0] s);
        return {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]};
    endfunction

endpackage

// File: rtl/snake_food_lfsr.sv
// Free-running 8-bit food LFSR, only present when SNAKE_FOOD_RAND_EN is defined.
`ifdef SNAKE_FOOD_RAND_EN
module snake_food_lfsr
    import snake_pkg::*;
(
    input  logic       clk_i,
    input  logic       rst_i,
    output logic [7:0] lfsr_o
);

    logic [7:0] lfsr_q;

    // Advance once per tick; seeded on reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            lfsr_q <= LFSR_SEED;
        end else begin
            lfsr_q <= lfsr8_next(lfsr_q);
        end
    end

    assign lfsr_o = lfsr_q;

endmodule
`endif

// File: rtl/snake_check.sv
// Snake frame checker: scans segments against the head for self-collision,
// flags eating the food and moves the food. Optional feature macro:
// SNAKE_FOOD_RAND_EN selects LFSR food placement instead of a fixed stride.
module snake_check
    import snake_pkg::*;
#(
    parameter int unsigned MAX_SEG = snake_pkg::MAX_SEG
) (
    input  logic                     slw_clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic [SEG_W*MAX_SEG-1:0] snake,
    input  logic [LEN_W-1:0]         len,
    output logic                     busy,
    output logic                     done,
    output logic                     ate,
    output logic                     game_over,
    output logic [GRID_W-1:0]        food_x,
    output logic [GRID_W-1:0]        food_y
);

    localparam int unsigned SNK_W  = SEG_W * MAX_SEG;
    localparam int unsigned SIDX_W = $clog2(SNK_W);

    state_t             state_q;
    logic [SNK_W-1:0]   snake_q;
    logic [LEN_W-1:0]   lenc_q;
    logic [LEN_W-1:0]   idx_q;
    seg_t               head_q;
    logic               hit_q;
    logic               eat_q;
    logic               busy_q;
    logic               done_q;
    logic               ate_q;
    logic               game_over_q;
    logic [GRID_W-1:0]  food_x_q;
    logic [GRID_W-1:0]  food_y_q;

    logic [LEN_W-1:0]   lenc_c;
    logic [SIDX_W-1:0]  hbase_c;
    logic [SIDX_W-1:0]  sbase_c;
    seg_t               head_c;
    seg_t               seg_c;
    logic               last_c;
    logic               hit_c;
    seg_t               food_nxt_c;

    // Clamp length, locate the incoming head and the segment under scan.
    always_comb begin
        lenc_c  = (32'(len) > MAX_SEG) ? LEN_W'(MAX_SEG) : len;
        hbase_c = (lenc_c == '0) ? '0 : SIDX_W'(SEG_W * (32'(lenc_c) - 32'd1));
        head_c  = snake[hbase_c +: SEG_W];
        sbase_c = SIDX_W'(SEG_W * 32'(idx_q));
        seg_c   = snake_q[sbase_c +: SEG_W];
        last_c  = (lenc_q <= LEN_W'(1)) || (idx_q == lenc_q - LEN_W'(2));
        hit_c   = hit_q || ((lenc_q > LEN_W'(1)) && (seg_c == head_q));
    end

`ifdef SNAKE_FOOD_RAND_EN
    logic [7:0] lfsr_w;

    snake_food_lfsr u_food_lfsr (
        .clk_i  (slw_clk),
        .rst_i  (reset),
        .lfsr_o (lfsr_w)
    );

    // New food is the value the LFSR steps to on the same edge.
    always_comb begin
        food_nxt_c = seg_t'(lfsr8_next(lfsr_w));
    end
`else
    // Fixed-stride food placement, wrapping on the 16x16 grid.
    always_comb begin
        food_nxt_c.x = food_x_q + FOOD_DX;
        food_nxt_c.y = food_y_q + FOOD_DY;
    end
`endif

    // Check sequencer: accept, scan one segment per tick, report.
    always_ff @(posedge slw_clk) begin
        if (reset) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            hit_q       <= 1'b0;
            eat_q       <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            ate_q       <= 1'b0;
            game_over_q <= 1'b0;
            food_x_q    <= FOOD_RST_X;
            food_y_q    <= FOOD_RST_Y;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start && !game_over_q) begin
                        snake_q <= snake;
                        lenc_q  <= lenc_c;
                        head_q  <= head_c;
                        idx_q   <= '0;
                        hit_q   <= 1'b0;
                        eat_q   <= (lenc_c != '0) && (head_c == {food_y_q, food_x_q});
                        busy_q  <= 1'b1;
                        state_q <= SCAN;
                    end
                end
                SCAN: begin
                    hit_q <= hit_c;
                    if (last_c) begin
                        done_q      <= 1'b1;
                        ate_q       <= eat_q;
                        game_over_q <= game_over_q | hit_c;
                        state_q     <= DONE;
                    end else begin
                        idx_q <= idx_q + LEN_W'(1);
                    end
                end
                DONE: begin
                    done_q  <= 1'b0;
                    ate_q   <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                    if (ate_q) begin
                        food_x_q <= food_nxt_c.x;
                        food_y_q <= food_nxt_c.y;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign ate       = ate_q;
    assign game_over = game_over_q;
    assign food_x    = food_x_q;
    assign food_y    = food_y_q;

endmodule
